// File: rtl/fll_dco_ctrl_if.sv
// Control-path interface of the FLL DCO stage: controller result in, DCO code and lock status out.
// Only the handshake/bus signals live here; clk_ref and reset stay plain module ports.
interface fll_dco_ctrl_if #(
  parameter int unsigned N           = 32,
  parameter int unsigned COARSE_BITS = 4,
  parameter int unsigned FINE_BITS   = 6
);
  logic                          enable;
  logic [N-1:0]                  value;
  logic                          strobe;
  logic                          locked;
  logic [2:0]                    corner;
  logic                          clear_lost;
  logic [COARSE_BITS+FINE_BITS-1:0] code_out;
  logic [2**COARSE_BITS-2:0]     coarse_therm;
  logic [FINE_BITS-1:0]          fine_bin;
  logic                          update;
  logic                          sat_hi;
  logic                          sat_lo;
  logic                          lock_stable;
  logic                          lock_lost;

  modport master (
    output enable, value, strobe, locked, corner, clear_lost,
    input  code_out, coarse_therm, fine_bin, update, sat_hi, sat_lo, lock_stable, lock_lost
  );

  modport slave (
    input  enable, value, strobe, locked, corner, clear_lost,
    output code_out, coarse_therm, fine_bin, update, sat_hi, sat_lo, lock_stable, lock_lost
  );
endinterface

// File: rtl/fll_dco_ctrl.sv
// Slew-limited DCO code generator with coarse thermometer / fine binary split
// and a debounced lock qualifier (lock_stable, sticky lock_lost).
module fll_dco_ctrl #(
  parameter int unsigned N            = 32,
  parameter int unsigned COARSE_BITS  = 4,
  parameter int unsigned FINE_BITS    = 6,
  parameter int unsigned MAX_STEP     = 4,
  parameter int unsigned INIT_CODE    = 512,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic           clk_ref,
  input  logic           reset,
  fll_dco_ctrl_if.slave  bus
);

  localparam int unsigned M    = COARSE_BITS + FINE_BITS;
  localparam int unsigned TW   = 2**COARSE_BITS - 1;
  localparam int unsigned LC_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UC_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [N-1:0]    CODE_MAX_N = N'(2**M - 1);
  localparam logic [M:0]      STEP       = (M+1)'(MAX_STEP);
  localparam logic [LC_W-1:0] LC_TOP     = LC_W'(LOCK_COUNT);
  localparam logic [UC_W-1:0] UC_TOP     = UC_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {DISABLED, ACQUIRE, STABLE} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    code_q, code_d;
  logic            update_q, update_d;
  logic            sat_hi_q, sat_hi_d;
  logic            sat_lo_q, sat_lo_d;
  logic            lock_lost_q, lock_lost_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [UC_W-1:0] unlock_cnt_q, unlock_cnt_d;

  logic            acc;
  logic            clip_hi, clip_lo;
  logic [M-1:0]    tgt;
  logic [M:0]      up_diff, dn_diff;
  logic            lost_set;
  logic [TW-1:0]   therm;

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state_q      <= DISABLED;
      code_q       <= M'(INIT_CODE);
      update_q     <= 1'b0;
      sat_hi_q     <= 1'b0;
      sat_lo_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      update_q     <= update_d;
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
      lock_lost_q  <= lock_lost_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
    end
  end

  // Datapath: target clipping and slew towards it, computed one bit wider so it never wraps.
  always_comb begin
    acc      = bus.strobe & bus.enable;
    clip_hi  = bus.value > CODE_MAX_N;
    clip_lo  = bus.value == '0;
    tgt      = clip_hi ? '1 : bus.value[M-1:0];
    up_diff  = {1'b0, tgt} - {1'b0, code_q};
    dn_diff  = {1'b0, code_q} - {1'b0, tgt};
    code_d   = code_q;
    update_d = 1'b0;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    if (acc) begin
      sat_hi_d = clip_hi | bus.corner[2];
      sat_lo_d = clip_lo | bus.corner[0];
      if (tgt > code_q) begin
        code_d = code_q + M'((up_diff > STEP) ? STEP : up_diff);
      end else if (tgt < code_q) begin
        code_d = code_q - M'((dn_diff > STEP) ? STEP : dn_diff);
      end
      update_d = (tgt != code_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    lost_set     = 1'b0;
    if (!bus.enable) begin
      state_d      = DISABLED;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d      = ACQUIRE;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
        end
        ACQUIRE: begin
          if (acc) begin
            if (!bus.locked) begin
              lock_cnt_d = '0;
            end else if (lock_cnt_q + 1'b1 >= LC_TOP) begin
              state_d    = STABLE;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end
        end
        STABLE: begin
          if (acc) begin
            if (bus.locked) begin
              unlock_cnt_d = '0;
            end else if (unlock_cnt_q + 1'b1 >= UC_TOP) begin
              state_d      = ACQUIRE;
              lock_cnt_d   = '0;
              unlock_cnt_d = '0;
              lost_set     = 1'b1;
            end else begin
              unlock_cnt_d = unlock_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = DISABLED;
      endcase
    end
    // A new loss of lock takes priority over a simultaneous clear request.
    if (lost_set) begin
      lock_lost_d = 1'b1;
    end else if (bus.clear_lost) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < TW; i++) begin
      therm[i] = i < 32'(code_q[M-1:FINE_BITS]);
    end
  end

  assign bus.code_out     = code_q;
  assign bus.coarse_therm = therm;
  assign bus.fine_bin     = code_q[FINE_BITS-1:0];
  assign bus.update       = update_q;
  assign bus.sat_hi       = sat_hi_q;
  assign bus.sat_lo       = sat_lo_q;
  assign bus.lock_stable  = (state_q == STABLE);
  assign bus.lock_lost    = lock_lost_q;

endmodule

// File: doc/fll_dco_ctrl.md
Name: fll_dco_ctrl

Overview:
Downstream stage of the FLL frequency controller. It consumes the controller's per-gate result: the N-bit control value, the strobe, locked and the 3-bit corner flags. It converts the value into a slew-limited M-bit DCO code split into a coarse thermometer field and a fine binary field for the ring-oscillator trim. It also qualifies the raw locked flag into a debounced lock_stable status and a sticky lock_lost flag.

Parameters:
N, 32, width of incoming control value
COARSE_BITS, 4, coarse code bits; thermometer width 2**COARSE_BITS-1
FINE_BITS, 6, fine binary bits; M = COARSE_BITS+FINE_BITS
MAX_STEP, 4, max code change per accepted strobe (1..2**M-1)
INIT_CODE, 512, code_out value after reset (must be < 2**M)
LOCK_COUNT, 4, consecutive locked strobes needed to assert lock_stable
UNLOCK_COUNT, 2, consecutive unlocked strobes needed to drop lock_stable

Ports:
clk_ref  in  1  reference clock; sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = accept strobes; 0 = hold code, ignore strobes
value  in  N  control value from FLL controller
strobe  in  1  1-cycle pulse: value/locked/corner valid
locked  in  1  controller in-band flag
corner  in  3  [2]=upper limit hit, [1]=nominal, [0]=lower limit hit
clear_lost  in  1  clears lock_lost
code_out  out  M  current DCO code
coarse_therm  out  2**COARSE_BITS-1  thermometer of code_out[M-1:FINE_BITS]
fine_bin  out  FINE_BITS  code_out[FINE_BITS-1:0]
update  out  1  1-cycle pulse when code_out changed
sat_hi  out  1  target clipped high or corner[2]
sat_lo  out  1  target clipped low or corner[0]
lock_stable  out  1  debounced lock
lock_lost  out  1  sticky: lock_stable fell

Behaviour:
- Single clock clk_ref. reset is synchronous and active-high. All state changes on the rising edge of clk_ref.
- Reset values:
  - code_out = INIT_CODE.
  - update = 0, sat_hi = 0, sat_lo = 0, lock_stable = 0, lock_lost = 0.
  - Lock/unlock counters = 0. FSM = DISABLED.
- Accepted strobe: strobe=1 and enable=1 and reset=0 on a clock edge. All other strobes are ignored, with no state change.
- Target:
  - tgt = min(value, 2**M-1), compared at full N-bit width.
  - clip_hi = value > 2**M-1. clip_lo = value == 0.
- Slew, evaluated at an accepted strobe edge (1-cycle latency from the strobe cycle to the new code_out):
  - if tgt > code_out: code_out += min(MAX_STEP, tgt-code_out)
  - if tgt < code_out: code_out -= min(MAX_STEP, code_out-tgt)
  - Differences are computed at M+1 bits. code_out never wraps.
- update: 1 for exactly the cycle after an accepted strobe that changed code_out; 0 otherwise, including when tgt == code_out.
- sat_hi and sat_lo: registered on each accepted strobe.
  - sat_hi = clip_hi | corner[2]; sat_lo = clip_lo | corner[0].
  - Both held between accepted strobes.
- coarse_therm and fine_bin: combinational from code_out. coarse_therm[i] = 1 iff i < code_out[M-1:FINE_BITS].
- FSM (states DISABLED, ACQUIRE, STABLE):
  - DISABLED: entered on reset or enable=0 from any state. lock_stable=0, counters cleared, code_out held. Leaving STABLE via enable=0 does NOT set lock_lost.
  - DISABLED -> ACQUIRE when enable=1.
  - ACQUIRE:
    - An accepted strobe with locked=1 increments lock_cnt (saturating at LOCK_COUNT).
    - An accepted strobe with locked=0 clears lock_cnt.
    - When lock_cnt reaches LOCK_COUNT on an accepted strobe, go to STABLE; lock_stable=1 from the next cycle.
  - STABLE:
    - An accepted strobe with locked=0 increments unlock_cnt; one with locked=1 clears it.
    - When unlock_cnt reaches UNLOCK_COUNT, go to ACQUIRE: lock_stable=0, lock_lost=1, both counters cleared.
- lock_lost: sticky. clear_lost=1 clears it on the next edge. If a set and clear_lost occur on the same edge, set wins.
- Code slewing continues in every enabled state; STABLE does not freeze the code.
- Reset mid-operation: reset overrides enable, strobe and clear_lost on that edge. All reset values are applied.

Test Plan:
- Reset with defaults -> code_out=512, coarse_therm=0x00FF, fine_bin=0, update=0, lock_stable=0, lock_lost=0.
- enable=1; strobes with value=522 -> code_out 516, then 520, then 522.
  - update pulses 1 cycle after each strobe.
  - A 4th strobe with value=522 gives no update.
- value=5000 strobe -> sat_hi=1, code steps +4 per strobe, reaching 1023 and holding.
- value=0 -> sat_lo=1, code steps -4 per strobe down to 0, never wrapping.
- 4 strobes with locked=1 -> lock_stable=1 after the 4th.
  - 1 strobe with locked=0, then 1 with locked=1 -> stays 1.
  - 2 strobes with locked=0 -> lock_stable=0, lock_lost=1.
  - clear_lost pulse -> lock_lost=0.
- Strobe with enable=0 and value=600 -> code_out unchanged, no update, lock_stable=0.
  - Dropping enable while STABLE leaves lock_lost=0.
- Reset asserted on the same edge as an accepted strobe with value=1000 -> code_out=512 and all flags cleared next cycle.
